// File: rtl/color_correction_matrix.sv
// color_correction_matrix
// Per-pixel 3x3 colour correction with a per-channel offset, placed after the
// demosaic block. Coefficients are double-buffered (shadow/active) so that a
// frame is never processed with a mix of old and new values. Fixed 3-cycle
// pipeline: products -> sum + offset + round -> shift + clamp.
module color_correction_matrix #(
   parameter int width  = 320,
   parameter int height = 240,
   parameter int DATA_W = 8,
   parameter int COEF_W = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] iR,
   input  logic [DATA_W-1:0] iG,
   input  logic [DATA_W-1:0] iB,
   input  logic              iValid,
   input  logic              iDone,
   input  logic              iCoefWe,
   input  logic [3:0]        iCoefAddr,
   input  logic [COEF_W-1:0] iCoefData,
   input  logic              iCommit,
   output logic [DATA_W-1:0] oR,
   output logic [DATA_W-1:0] oG,
   output logic [DATA_W-1:0] oB,
   output logic              oValid,
   output logic              oDone,
   output logic              oBusy,
   output logic [31:0]       xCnt,
   output logic [31:0]       yCnt,
   output logic [31:0]       frameCnt
);

   // Coefficients are Q3.8: 8 fractional bits.
   localparam int FRAC   = 8;
   localparam int OFF_W  = 10;
   localparam int PROD_W = COEF_W + DATA_W + 1;
   localparam int ACC_W  = PROD_W + 3;
   localparam logic signed [COEF_W-1:0] ONE     = COEF_W'(1 << FRAC);
   localparam logic signed [ACC_W-1:0]  PIX_MAX = ACC_W'((1 << DATA_W) - 1);

   // Adds the integer offset (aligned to the fraction point) and half an LSB
   // so the later arithmetic shift rounds to nearest.
   function automatic logic signed [ACC_W-1:0] add_offset_round(
      input logic signed [ACC_W-1:0] sum,
      input logic signed [OFF_W-1:0] off
   );
      logic signed [ACC_W-1:0] off_ext;
      logic signed [ACC_W-1:0] half;
      off_ext = ACC_W'(off);
      half    = ACC_W'(1 << (FRAC - 1));
      return sum + (off_ext <<< FRAC) + half;
   endfunction

   // Drops the fraction and clamps to the unsigned pixel range.
   function automatic logic [DATA_W-1:0] clamp_pix(input logic signed [ACC_W-1:0] acc);
      logic signed [ACC_W-1:0] q;
      q = acc >>> FRAC;
      if (q[ACC_W-1])
         return '0;
      else if (q > PIX_MAX)
         return '1;
      else
         return q[DATA_W-1:0];
   endfunction

   // Matrix entries 0..8 are row-major (row = output channel), offsets per channel.
   logic signed [COEF_W-1:0] sh_c    [0:8];
   logic signed [OFF_W-1:0]  sh_off  [0:2];
   logic signed [COEF_W-1:0] act_c   [0:8];
   logic signed [OFF_W-1:0]  act_off [0:2];

   logic busy;
   logic commit;
   logic [DATA_W-1:0] pix [0:2];

   // A frame boundary always commits; an explicit commit only while idle.
   assign commit = iDone | (iCommit & ~busy);

   // Gather the input pixel so the matrix can be walked by column index.
   always_comb begin
      pix[0] = iR;
      pix[1] = iG;
      pix[2] = iB;
   end

   // Shadow bank: host writes land here; addresses 12..15 are dropped.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 9; i++)
            sh_c[i] <= (i % 4 == 0) ? ONE : '0;
         for (int i = 0; i < 3; i++)
            sh_off[i] <= '0;
      end else if (iCoefWe) begin
         if (iCoefAddr < 4'd9)
            sh_c[iCoefAddr] <= iCoefData;
         else if (iCoefAddr < 4'd12)
            sh_off[2'(iCoefAddr - 4'd9)] <= iCoefData[OFF_W-1:0];
      end
   end

   // Active bank: takes the pre-write shadow contents on a commit.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 9; i++)
            act_c[i] <= (i % 4 == 0) ? ONE : '0;
         for (int i = 0; i < 3; i++)
            act_off[i] <= '0;
      end else if (commit) begin
         act_c   <= sh_c;
         act_off <= sh_off;
      end
   end

   // Frame-in-progress flag: raised by the first valid pixel, dropped after iDone.
   always_ff @(posedge clk) begin
      if (!reset)
         busy <= 1'b0;
      else if (iDone)
         busy <= 1'b0;
      else if (iValid)
         busy <= 1'b1;
   end

   // ---- Stage 1: nine products, offsets captured with the pixel ----
   logic signed [PROD_W-1:0] prod_p0 [0:8];
   logic signed [OFF_W-1:0]  off_p0  [0:2];
   logic                     vld_p0;
   logic                     done_p0;

   // Products use the coefficients active when the pixel was accepted.
   always_ff @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         for (int j = 0; j < 3; j++)
            prod_p0[3*k+j] <= PROD_W'(act_c[3*k+j]) * PROD_W'(signed'({1'b0, pix[j]}));
         off_p0[k] <= act_off[k];
      end
   end

   // ---- Stage 2: sum of products, offset and rounding constant ----
   logic signed [ACC_W-1:0] acc_p1 [0:2];
   logic                    vld_p1;
   logic                    done_p1;

   // One accumulator per output channel.
   always_ff @(posedge clk) begin
      for (int k = 0; k < 3; k++)
         acc_p1[k] <= add_offset_round(ACC_W'(prod_p0[3*k]) + ACC_W'(prod_p0[3*k+1])
                                       + ACC_W'(prod_p0[3*k+2]), off_p0[k]);
   end

   // ---- Stage 3: shift, clamp, output register ----
   logic [DATA_W-1:0] pix_p2 [0:2];
   logic              vld_p2;
   logic              done_p2;

   // Output pixel register, cleared by reset so the port idles at zero.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int k = 0; k < 3; k++)
            pix_p2[k] <= '0;
      end else begin
         for (int k = 0; k < 3; k++)
            pix_p2[k] <= clamp_pix(acc_p1[k]);
      end
   end

   // Valid/done travel beside the data; reset flushes anything in flight.
   always_ff @(posedge clk) begin
      if (!reset) begin
         vld_p0  <= 1'b0;
         done_p0 <= 1'b0;
         vld_p1  <= 1'b0;
         done_p1 <= 1'b0;
         vld_p2  <= 1'b0;
         done_p2 <= 1'b0;
      end else begin
         vld_p0  <= iValid;
         done_p0 <= iDone;
         vld_p1  <= vld_p0;
         done_p1 <= done_p0;
         vld_p2  <= vld_p1;
         done_p2 <= done_p1;
      end
   end

   // Position of the pixel on the output; end of frame wins over a valid pixel.
   always_ff @(posedge clk) begin
      if (!reset) begin
         xCnt     <= '0;
         yCnt     <= '0;
         frameCnt <= '0;
      end else if (done_p2) begin
         xCnt     <= '0;
         yCnt     <= '0;
         frameCnt <= frameCnt + 32'd1;
      end else if (vld_p2) begin
         if (xCnt == 32'(width - 1)) begin
            xCnt <= '0;
            if (yCnt < 32'(height - 1))
               yCnt <= yCnt + 32'd1;
         end else begin
            xCnt <= xCnt + 32'd1;
         end
      end
   end

   assign oR     = pix_p2[0];
   assign oG     = pix_p2[1];
   assign oB     = pix_p2[2];
   assign oValid = vld_p2;
   assign oDone  = done_p2;
   assign oBusy  = busy;

endmodule

// File: tb/tb_color_correction_matrix.sv
// Testbench for color_correction_matrix: directed cases plus randomized frames,
// checked cycle by cycle against a behavioural model of the colour matrix.
module tb_color_correction_matrix;

   localparam int W = 320;
   localparam int H = 240;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  iR, iG, iB;
   logic        iValid, iDone, iCoefWe, iCommit;
   logic [3:0]  iCoefAddr;
   logic [11:0] iCoefData;
   logic [7:0]  oR, oG, oB;
   logic        oValid, oDone, oBusy;
   logic [31:0] xCnt, yCnt, frameCnt;

   always #5 clk = ~clk;

   color_correction_matrix dut (
      .clk       (clk),
      .reset     (reset),
      .iR        (iR),
      .iG        (iG),
      .iB        (iB),
      .iValid    (iValid),
      .iDone     (iDone),
      .iCoefWe   (iCoefWe),
      .iCoefAddr (iCoefAddr),
      .iCoefData (iCoefData),
      .iCommit   (iCommit),
      .oR        (oR),
      .oG        (oG),
      .oB        (oB),
      .oValid    (oValid),
      .oDone     (oDone),
      .oBusy     (oBusy),
      .xCnt      (xCnt),
      .yCnt      (yCnt),
      .frameCnt  (frameCnt)
   );

   typedef struct {
      bit v;
      bit d;
      int r;
      int g;
      int b;
   } exp_t;

   exp_t sb[$];
   int   m_sh  [12];
   int   m_act [12];
   int   cfg   [12];
   bit   m_busy;
   int   m_x, m_y, m_f;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_ovalid = 0;
   int   fc;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Model: entries 0..8 = matrix (signed, 256 = 1.0), 9..11 = integer offsets.
   function automatic int ref_chan(input int k, input int r, input int g, input int b);
      int acc;
      int q;
      acc = m_act[3*k]*r + m_act[3*k+1]*g + m_act[3*k+2]*b + m_act[9+k]*256 + 128;
      q = acc >>> 8;
      if (q < 0) return 0;
      if (q > 255) return 255;
      return q;
   endfunction

   function automatic int decode(input int addr, input logic [11:0] d);
      logic [9:0] o;
      o = d[9:0];
      if (addr < 9) return int'($signed(d));
      return int'($signed(o));
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 12; i++) begin
         m_sh[i]  = (i == 0 || i == 4 || i == 8) ? 256 : 0;
         m_act[i] = m_sh[i];
      end
      m_busy = 1'b0;
      m_x = 0;
      m_y = 0;
      m_f = 0;
      sb.delete();
   endtask

   // One clock: update the model from the driven inputs, clock, then compare.
   task automatic tick();
      exp_t e;
      exp_t o;
      bit   cm;
      if (!reset) begin
         model_reset();
         e.v = 1'b0; e.d = 1'b0; e.r = 0; e.g = 0; e.b = 0;
         repeat (3) sb.push_back(e);
      end else begin
         e.v = iValid;
         e.d = iDone;
         e.r = ref_chan(0, int'(iR), int'(iG), int'(iB));
         e.g = ref_chan(1, int'(iR), int'(iG), int'(iB));
         e.b = ref_chan(2, int'(iR), int'(iG), int'(iB));
         sb.push_back(e);
         cm = iDone || (iCommit && !m_busy);
         if (cm) m_act = m_sh;
         if (iCoefWe && iCoefAddr < 4'd12)
            m_sh[iCoefAddr] = decode(int'(iCoefAddr), iCoefData);
         if (iDone) m_busy = 1'b0;
         else if (iValid) m_busy = 1'b1;
      end
      @(posedge clk);
      #1;
      if (oValid) n_ovalid++;
      o = sb.pop_front();
      check_eq("oValid", 32'(oValid), 32'(o.v));
      check_eq("oDone", 32'(oDone), 32'(o.d));
      if (o.v) begin
         check_eq("oR", 32'(oR), o.r);
         check_eq("oG", 32'(oG), o.g);
         check_eq("oB", 32'(oB), o.b);
      end
      check_eq("xCnt", xCnt, m_x);
      check_eq("yCnt", yCnt, m_y);
      check_eq("frameCnt", frameCnt, m_f);
      check_eq("oBusy", 32'(oBusy), 32'(m_busy));
      if (o.d) begin
         m_x = 0;
         m_y = 0;
         m_f++;
      end else if (o.v) begin
         if (m_x == W - 1) begin
            m_x = 0;
            if (m_y < H - 1) m_y++;
         end else begin
            m_x++;
         end
      end
   endtask

   task automatic idle_inputs();
      iValid  = 1'b0;
      iDone   = 1'b0;
      iCoefWe = 1'b0;
      iCommit = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic px(input int r, input int g, input int b);
      iR = 8'(r);
      iG = 8'(g);
      iB = 8'(b);
      iValid = 1'b1;
      tick();
      iValid = 1'b0;
   endtask

   task automatic wr(input int addr, input int data);
      iCoefWe   = 1'b1;
      iCoefAddr = 4'(addr);
      iCoefData = 12'(data);
      tick();
      iCoefWe = 1'b0;
   endtask

   task automatic load_cfg();
      for (int i = 0; i < 12; i++) wr(i, cfg[i]);
      iCommit = 1'b1;
      tick();
      iCommit = 1'b0;
   endtask

   task automatic end_frame();
      iDone = 1'b1;
      tick();
      iDone = 1'b0;
      idle(4);
   endtask

   task automatic check_rgb(input string tag, input int r, input int g, input int b);
      check_eq({tag, "_valid"}, 32'(oValid), 32'd1);
      check_eq({tag, "_r"}, 32'(oR), r);
      check_eq({tag, "_g"}, 32'(oG), g);
      check_eq({tag, "_b"}, 32'(oB), b);
   endtask

   function automatic logic [11:0] rnd_coef();
      if ($urandom_range(0, 1) == 0)
         return 12'(int'($urandom_range(0, 768)) - 384);
      return 12'($urandom);
   endfunction

   initial begin
      idle_inputs();
      iR = '0; iG = '0; iB = '0;
      iCoefAddr = '0;
      iCoefData = '0;
      reset = 1'b0;
      tick();
      tick();
      check_eq("rst_oR", 32'(oR), 32'd0);
      check_eq("rst_oG", 32'(oG), 32'd0);
      check_eq("rst_oB", 32'(oB), 32'd0);
      check_eq("rst_oValid", 32'(oValid), 32'd0);
      check_eq("rst_frameCnt", frameCnt, 32'd0);
      reset = 1'b1;
      tick();

      // Identity straight after reset.
      px(10, 128, 250);
      idle(2);
      check_rgb("identity", 10, 128, 250);
      check_eq("identity_x", xCnt, 32'd0);
      check_eq("identity_y", yCnt, 32'd0);
      end_frame();

      // Swap R and G.
      cfg = '{0, 256, 0, 256, 0, 0, 0, 0, 256, 0, 0, 0};
      load_cfg();
      px(10, 128, 250);
      idle(2);
      check_rgb("swap", 128, 10, 250);
      end_frame();

      // Gain 2.0 saturates R.
      cfg = '{512, 0, 0, 0, 512, 0, 0, 0, 512, 0, 0, 0};
      load_cfg();
      px(200, 1, 0);
      idle(2);
      check_rgb("gain2", 255, 2, 0);
      end_frame();

      // 0.5 * 3 = 1.5 rounds up to 2.
      cfg = '{128, 0, 0, 0, 256, 0, 0, 0, 256, 0, 0, 0};
      load_cfg();
      px(3, 0, 0);
      idle(2);
      check_rgb("round", 2, 0, 0);
      end_frame();

      // Offset R = -20 (bits 11:10 set to junk) clamps to 0.
      cfg = '{256, 0, 0, 0, 256, 0, 0, 0, 256, 'h7EC, 0, 0};
      load_cfg();
      px(5, 5, 5);
      idle(2);
      check_rgb("offset", 0, 5, 5);
      end_frame();

      // Deferred commit: writes mid-frame only take effect after iDone.
      cfg = '{256, 0, 0, 0, 256, 0, 0, 0, 256, 0, 0, 0};
      load_cfg();
      px(10, 20, 30);
      wr(0, 512);
      wr(4, 512);
      wr(8, 512);
      iCommit = 1'b1;
      tick();
      iCommit = 1'b0;
      check_eq("defer_busy", 32'(oBusy), 32'd1);
      px(10, 20, 30);
      idle(2);
      check_rgb("defer_mid", 10, 20, 30);
      fc = int'(frameCnt);
      iR = 8'd10; iG = 8'd20; iB = 8'd30;
      iValid = 1'b1;
      iDone  = 1'b1;
      tick();
      iValid = 1'b0;
      iDone  = 1'b0;
      px(10, 20, 30);
      tick();
      check_rgb("defer_last", 10, 20, 30);
      check_eq("defer_done", 32'(oDone), 32'd1);
      tick();
      check_rgb("defer_next", 20, 40, 60);
      check_eq("defer_frames", frameCnt, 32'(fc + 1));
      end_frame();

      // Full frame.
      n_ovalid = 0;
      for (int i = 0; i < W * H; i++)
         px(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      iDone = 1'b1;
      tick();
      iDone = 1'b0;
      tick();
      check_eq("frame_last_valid", 32'(oValid), 32'd1);
      check_eq("frame_last_x", xCnt, 32'(W - 1));
      check_eq("frame_last_y", yCnt, 32'(H - 1));
      tick();
      check_eq("frame_done", 32'(oDone), 32'd1);
      tick();
      check_eq("frame_end_x", xCnt, 32'd0);
      check_eq("frame_end_y", yCnt, 32'd0);
      check_eq("frame_valid_count", 32'(n_ovalid), 32'(W * H));
      idle(2);

      // Reset mid-frame with three pixels in flight (active gain is 2.0 here).
      px(1, 2, 3);
      px(4, 5, 6);
      px(7, 8, 9);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("rstmid_no_valid", 32'(oValid), 32'd0);
      end
      check_eq("rstmid_busy", 32'(oBusy), 32'd0);
      px(10, 128, 250);
      idle(2);
      check_rgb("rstmid_identity", 10, 128, 250);
      end_frame();

      // Randomized frames with random writes and commits.
      for (int f = 0; f < 15; f++) begin
         int len;
         len = int'($urandom_range(20, 60));
         for (int c = 0; c < len; c++) begin
            iValid    = ($urandom_range(0, 3) != 0);
            iR        = 8'($urandom);
            iG        = 8'($urandom);
            iB        = 8'($urandom);
            iCoefWe   = ($urandom_range(0, 7) == 0);
            iCoefAddr = 4'($urandom);
            iCoefData = rnd_coef();
            iCommit   = ($urandom_range(0, 15) == 0);
            tick();
         end
         idle_inputs();
         iDone     = 1'b1;
         iValid    = ($urandom_range(0, 1) == 1);
         iCoefWe   = ($urandom_range(0, 1) == 1);
         iCoefAddr = 4'($urandom_range(0, 11));
         iCoefData = rnd_coef();
         tick();
         idle_inputs();
         for (int g = 0; g < int'($urandom_range(1, 4)); g++) begin
            iCommit   = ($urandom_range(0, 1) == 1);
            iCoefWe   = ($urandom_range(0, 1) == 1);
            iCoefAddr = 4'($urandom);
            iCoefData = rnd_coef();
            tick();
         end
         idle_inputs();
      end
      idle(4);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/color_correction_matrix.md
# color_correction_matrix

Per-pixel 3x3 colour-correction stage placed directly downstream of the demosaic block. It consumes the demosaic RGB stream (8-bit R/G/B, valid, done) and applies a programmable signed 3x3 matrix plus per-channel offset. The result is rounded, clamped to 8 bits and emitted through a fixed 3-cycle pipeline. Coefficient writes are double-buffered and take effect only at a frame boundary, so a frame is never processed with mixed coefficients.

## Interface
- width, 320, pixels per row; used by the output position counters
- height, 240, rows per frame; used by the output position counters
- clk  input  1  single clock; all logic on the rising edge
- reset  input  1  synchronous, active-low reset (reset==0 clears state on the next edge)
- iR, iG, iB  input  8 each  unsigned pixel from demosaic
- iValid  input  1  pixel qualifier
- iDone  input  1  one-cycle end-of-frame pulse from demosaic
- iCoefWe  input  1  shadow-register write strobe
- iCoefAddr  input  4  0..8 = matrix C[row][col], row-major (row 0 = R out); 9..11 = offset R/G/B; 12..15 ignored
- iCoefData  input  12  coefficient: signed Q3.8. Offset: signed integer in bits [9:0]; bits [11:10] are ignored
- iCommit  input  1  request immediate shadow->active copy when not busy
- oR, oG, oB  output  8 each  corrected pixel
- oValid  output  1  output pixel qualifier
- oDone  output  1  end-of-frame pulse, aligned with the pipeline
- oBusy  output  1  a frame is in progress
- xCnt, yCnt  output  32 each  position of the pixel currently on oR/oG/oB
- frameCnt  output  32  number of oDone pulses since reset

## Operation
- Two register sets: shadow (write side) and active (datapath side).
- Reset values of both sets: identity. The diagonal C00/C11/C22 = 12'h100 (1.0); all other coefficients = 0; offsets = 0.
- iCoefWe writes iCoefData into shadow[iCoefAddr]. Addresses 12..15 are dropped.
- Commit (active <= shadow) happens on the cycle iDone==1, or on the cycle iCommit==1 && oBusy==0.
  - The new values apply to pixels accepted from the next cycle on.
  - A commit and a write in the same cycle: the commit copies the pre-write shadow. The write lands in shadow only.
- oBusy is set on the first cycle with iValid==1 while oBusy==0. It clears on the cycle after iDone.
- Arithmetic per output channel k: acc = sum over j of C[k][j] * {1'b0, P[j]} + (offset_k <<< 8) + 128.
  - Products are 21-bit signed; acc is 24-bit signed.
  - result = acc >>> 8 (arithmetic shift). If result < 0, output 0; if result > 255, output 255; otherwise output result[7:0].
- Pipeline stages:
  - S1: register the 9 products and the valid/done bits.
  - S2: sum the products, add the offset and the rounding constant.
  - S3: shift, clamp and register the outputs.
- The pipeline runs every cycle. Valid and done bits flow alongside the data; iValid does not stall it.
- Position counters, updated each cycle:
  - On oValid, xCnt increments. At width-1 it wraps to 0 and yCnt increments.
  - On oDone, xCnt and yCnt clear to 0 and frameCnt increments; this takes priority over a simultaneous oValid.
  - yCnt saturates at height-1 if the frame is over-long.

## Timing
- Latency: iValid/iDone in cycle N produces oValid/oDone in cycle N+3, together with the corresponding pixel.
- Throughput: one pixel per cycle; back-to-back valid is allowed.
- Reset values: oR/oG/oB = 0, oValid = 0, oDone = 0, oBusy = 0, xCnt = yCnt = 0, frameCnt = 0, all pipeline valid/done bits = 0.
- Reset mid-frame:
  - In-flight pixels are discarded, with no oValid afterwards.
  - Both coefficient sets return to identity.
- Pixels with iValid==0 never produce oValid, even when iDone is high in the same cycle.
- A commit on iDone affects no pixel of the frame that iDone closes.

## Test plan
- Identity after reset: iR/iG/iB = 10/128/250 with iValid -> three cycles later oR/oG/oB = 10/128/250, oValid = 1, xCnt = 0, yCnt = 0.
- Program swap matrix (C01 = C10 = C22 = 0x100, other coefficients 0), then iCommit with oBusy = 0. Input 10/128/250 -> output 128/10/250.
- Saturation and rounding:
  - Gain 2.0 (0x200) on the diagonal with input 200/1/0 -> output 255/2/0.
  - C00 = 0x080 (0.5) with iR = 3 -> oR = 2 (1.5 rounds up).
  - Offset R = -20 with iR = 5 -> oR = 0.
- Deferred commit: write gain 2.0 mid-frame while oBusy = 1.
  - The rest of that frame stays at identity.
  - The pixel following iDone is doubled.
  - frameCnt increments exactly once.
- Full 320x240 frame of iValid, then iDone:
  - 76800 oValid pulses.
  - Last pixel shows xCnt = 319, yCnt = 239.
  - oDone arrives 3 cycles after iDone; the counters are then 0.
- Reset low for one cycle mid-frame, with three pixels in flight:
  - No oValid in the following 3 cycles.
  - oBusy = 0.
  - A subsequent pixel passes with identity.
